ym3438_slot_counter: RTL and testbench

- Time-multiplexed bank of SLOTS independent DATA_WIDTH-bit counters held in a two-phase (c1/c2) circular shift ring.
- Only the head slot is visible and updated each slot period, so one adder serves all slots, in the same way the chip's per-channel and per-operator state rotates.
- Generalises the single-slot counter primitive with per-slot depth, a multi-bit step, load, saturating mode, a slot index/sync output and a serial debug read-out chain.

---
 rtl/ym3438_slot_counter_pkg.sv | 17 +
 rtl/ym3438_slot_counter_if.sv | 39 +++
 rtl/ym3438_slot_ring.sv | 36 +++
 rtl/ym3438_slot_counter.sv | 89 ++++++++
 tb/tb_ym3438_slot_counter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ym3438_slot_counter_pkg.sv
// Shared definitions for the time-multiplexed slot counter: default
// geometry and the helper that sizes the slot index.
package ym3438_slot_counter_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_SLOTS      = 24;
  localparam int DEF_STEP_WIDTH = 1;

  // Width of an index able to name every slot; never narrower than one bit.
  function automatic int slot_bits(input int slots);
    int b;
    b = 0;
    while ((1 << b) < slots) b++;
    return (b < 1) ? 1 : b;
  endfunction

endpackage

// File: rtl/ym3438_slot_counter_if.sv
// Bus bundle between a controller (master) and the slot counter (slave).
//
// Strobe semantics: there is no valid/ready pair. c1 and c2 are single-cycle
// phase enables sampled on the rising master clock. c1 captures the next head
// value (and steps the debug shifter); c2 rotates the ring one slot. The
// remaining inputs are only meaningful in a cycle where c1 is high; outputs
// describe the slot currently at the head and are valid every cycle after
// the first reset.
interface ym3438_slot_counter_if
  import ym3438_slot_counter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int STEP_WIDTH = DEF_STEP_WIDTH,
  parameter int SLOT_BITS  = slot_bits(DEF_SLOTS)
);
  logic                  c1;
  logic                  c2;
  logic [STEP_WIDTH-1:0] inc;
  logic                  clr;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_val;
  logic                  dbg_load;
  logic                  dbg_in;
  logic [DATA_WIDTH-1:0] val;
  logic                  c_out;
  logic [SLOT_BITS-1:0]  slot;
  logic                  sync;
  logic                  dbg_out;

  modport master (
    output c1, c2, inc, clr, load, load_val, dbg_load, dbg_in,
    input  val, c_out, slot, sync, dbg_out
  );

  modport slave (
    input  c1, c2, inc, clr, load, load_val, dbg_load, dbg_in,
    output val, c_out, slot, sync, dbg_out
  );
endinterface

// File: rtl/ym3438_slot_ring.sv
// Two-phase per-slot storage: a stage latch v1 written on c1 followed by a
// SLOTS-deep circular shift ring advanced on c2. Only the last ring stage
// (the head) is visible, so a single datapath can serve every slot.
module ym3438_slot_ring #(
  parameter int DATA_WIDTH = 8,
  parameter int SLOTS      = 24
) (
  input  logic                  MCLK,
  input  logic                  reset,
  input  logic                  c1,
  input  logic                  c2,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] v1_q;
  logic [DATA_WIDTH-1:0] ring_q [SLOTS];

  // Stage latch captures on c1; ring shifts on c2 using the old v1, so an
  // overlapping c1/c2 inserts the previous stage value.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      v1_q <= '0;
      for (int i = 0; i < SLOTS; i++) ring_q[i] <= '0;
    end else begin
      if (c1) v1_q <= data_in;
      if (c2) begin
        ring_q[0] <= v1_q;
        for (int i = 1; i < SLOTS; i++) ring_q[i] <= ring_q[i-1];
      end
    end
  end

  assign head = ring_q[SLOTS-1];

endmodule

// File: rtl/ym3438_slot_counter.sv
// Bank of SLOTS counters sharing one adder: the head slot of a rotating
// ring is stepped/loaded/cleared on c1 and the ring turns on c2. Also keeps
// a slot index with a sync flag and a serial debug read-out shifter.
module ym3438_slot_counter
  import ym3438_slot_counter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SLOTS      = DEF_SLOTS,
  parameter int STEP_WIDTH = DEF_STEP_WIDTH,
  parameter int SATURATE   = 0
) (
  input logic                  MCLK,
  input logic                  reset,
  ym3438_slot_counter_if.slave bus
);

  localparam int SLOT_BITS = slot_bits(SLOTS);
  localparam logic [SLOT_BITS-1:0] LAST_SLOT = SLOT_BITS'(SLOTS - 1);

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] base;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] res;
  logic [DATA_WIDTH-1:0] nxt_d;
  logic [DATA_WIDTH-1:0] chain;
  logic [DATA_WIDTH-1:0] dbg_d;
  logic [DATA_WIDTH-1:0] dbg_q;
  logic [SLOT_BITS-1:0]  slot_d;
  logic [SLOT_BITS-1:0]  slot_q;

  ym3438_slot_ring #(
    .DATA_WIDTH (DATA_WIDTH),
    .SLOTS      (SLOTS)
  ) u_ring (
    .MCLK    (MCLK),
    .reset   (reset),
    .c1      (bus.c1),
    .c2      (bus.c2),
    .data_in (nxt_d),
    .head    (head)
  );

  // Shared adder: load replaces the head, clear wins over everything but the
  // carry still reports the addition that would have happened.
  always_comb begin
    base  = bus.load ? bus.load_val : head;
    sum   = {1'b0, base} + {{(DATA_WIDTH + 1 - STEP_WIDTH){1'b0}}, bus.inc};
    res   = ((SATURATE != 0) && sum[DATA_WIDTH]) ? '1 : sum[DATA_WIDTH-1:0];
    nxt_d = bus.clr ? '0 : res;
  end

  // Serial chain term: shifter contents moved up one bit with dbg_in entering
  // at the bottom; a one-bit shifter simply takes dbg_in.
  generate
    if (DATA_WIDTH == 1) begin : g_chain_1
      assign chain = bus.dbg_in;
    end else begin : g_chain_n
      assign chain = {dbg_q[DATA_WIDTH-2:0], bus.dbg_in};
    end
  endgenerate

  // Debug shifter next value: optional OR-merge of the head into the chain.
  always_comb begin
    dbg_d = bus.dbg_load ? (head | chain) : chain;
  end

  // Slot index follows c2 with an explicit wrap so non-power-of-two banks work.
  always_comb begin
    slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_BITS'(1);
  end

  // Debug shifter steps on c1, slot index on c2; reset overrides both.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      dbg_q  <= '0;
      slot_q <= '0;
    end else begin
      if (bus.c1) dbg_q  <= dbg_d;
      if (bus.c2) slot_q <= slot_d;
    end
  end

  assign bus.val     = head;
  assign bus.c_out   = sum[DATA_WIDTH];
  assign bus.slot    = slot_q;
  assign bus.sync    = (slot_q == '0);
  assign bus.dbg_out = dbg_q[DATA_WIDTH-1];

endmodule

// File: tb/tb_ym3438_slot_counter.sv
// Bench for the slot counter: a wrapping and a saturating instance (W=4,
// SLOTS=3, 2-bit step) receive identical stimulus. A slot-indexed reference
// model pushes the expected outputs of every cycle into a queue per instance;
// a monitor pops and compares at each falling edge. Directed phases also
// check hand-computed head values, carries and the debug bit stream.
module tb_ym3438_slot_counter;

  localparam int W  = 4;
  localparam int S  = 3;
  localparam int SW = 2;
  localparam int SB = 2;

  logic mclk;
  logic reset;

  int total = 0;
  int bad   = 0;
  bit sb_on = 0;

  // expected vector: {slot[1:0], sync, val[3:0], c_out, dbg_out}
  logic [8:0] exp0_q[$];
  logic [8:0] exp1_q[$];

  logic [W-1:0] m_mem  [2][S];
  logic [W-1:0] m_v1   [2];
  logic [W-1:0] m_d    [2];
  int           m_slot [2];

  ym3438_slot_counter_if #(.DATA_WIDTH(W), .STEP_WIDTH(SW), .SLOT_BITS(SB)) if0 ();
  ym3438_slot_counter_if #(.DATA_WIDTH(W), .STEP_WIDTH(SW), .SLOT_BITS(SB)) if1 ();

  ym3438_slot_counter #(.DATA_WIDTH(W), .SLOTS(S), .STEP_WIDTH(SW), .SATURATE(0)) dut0 (
    .MCLK (mclk), .reset (reset), .bus (if0)
  );
  ym3438_slot_counter #(.DATA_WIDTH(W), .SLOTS(S), .STEP_WIDTH(SW), .SATURATE(1)) dut1 (
    .MCLK (mclk), .reset (reset), .bus (if1)
  );

  // clock / reset
  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // driver: apply one cycle of inputs, push the expected outputs seen during
  // this cycle, then advance the model to the state after the next edge
  task automatic set_in(input bit c1, input bit c2, input int inc, input bit clr,
                        input bit ld, input int lv, input bit dbl, input bit dbi,
                        input bit rst);
    logic [W-1:0] head, base, res, nxt, chain, dn;
    logic [W:0]   sum;
    reset       = rst;
    if0.c1 = c1;  if0.c2 = c2;  if0.inc = SW'(inc); if0.clr = clr; if0.load = ld;
    if0.load_val = W'(lv); if0.dbg_load = dbl; if0.dbg_in = dbi;
    if1.c1 = c1;  if1.c2 = c2;  if1.inc = SW'(inc); if1.clr = clr; if1.load = ld;
    if1.load_val = W'(lv); if1.dbg_load = dbl; if1.dbg_in = dbi;
    for (int k = 0; k < 2; k++) begin
      head = m_mem[k][m_slot[k]];
      base = ld ? W'(lv) : head;
      sum  = {1'b0, base} + (W+1)'(inc);
      if (sb_on) begin
        if (k == 0) exp0_q.push_back({SB'(m_slot[k]), m_slot[k] == 0, head, sum[W], m_d[k][W-1]});
        else        exp1_q.push_back({SB'(m_slot[k]), m_slot[k] == 0, head, sum[W], m_d[k][W-1]});
      end
      res   = (k == 1 && sum[W]) ? {W{1'b1}} : sum[W-1:0];
      nxt   = clr ? '0 : res;
      chain = {m_d[k][W-2:0], dbi};
      dn    = dbl ? (head | chain) : chain;
      if (rst) begin
        for (int i = 0; i < S; i++) m_mem[k][i] = '0;
        m_v1[k] = '0; m_d[k] = '0; m_slot[k] = 0;
      end else begin
        if (c2) begin
          m_mem[k][m_slot[k]] = m_v1[k];
          m_slot[k] = (m_slot[k] == S - 1) ? 0 : m_slot[k] + 1;
        end
        if (c1) begin
          m_v1[k] = nxt;
          m_d[k]  = dn;
        end
      end
    end
    @(negedge mclk);
  endtask

  task automatic adv();
    @(posedge mclk);
    #1;
  endtask

  // one slot period: c1 cycle with the operation, then a c2 cycle; optional
  // hand checks (value -1 means skip) during the c1 cycle
  task automatic period(input string nm, input int inc, input bit clr, input bit ld,
                        input int lv, input int es, input int ev0, input int ev1,
                        input int ec0, input int ec1);
    set_in(1, 0, inc, clr, ld, lv, 0, 0, 0);
    if (es  >= 0) chk({nm, "_slot"},  9'(if0.slot),  9'(es));
    if (ev0 >= 0) chk({nm, "_val0"},  9'(if0.val),   9'(ev0));
    if (ev1 >= 0) chk({nm, "_val1"},  9'(if1.val),   9'(ev1));
    if (ec0 >= 0) chk({nm, "_cout0"}, 9'(if0.c_out), 9'(ec0));
    if (ec1 >= 0) chk({nm, "_cout1"}, 9'(if1.c_out), 9'(ec1));
    adv();
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
    adv();
  endtask

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge mclk);
      if (exp0_q.size() > 0)
        chk("sb_wrap", {if0.slot, if0.sync, if0.val, if0.c_out, if0.dbg_out}, exp0_q.pop_front());
      if (exp1_q.size() > 0)
        chk("sb_sat", {if1.slot, if1.sync, if1.val, if1.c_out, if1.dbg_out}, exp1_q.pop_front());
    end
  end

  // stimulus
  initial begin
    bit dbg_exp [5];
    dbg_exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < S; i++) m_mem[k][i] = '0;
      m_v1[k] = '0; m_d[k] = '0; m_slot[k] = 0;
    end

    // reset
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    adv();
    sb_on = 1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    adv();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_val",  9'(if0.val),     9'd0);
    chk("rst_slot", 9'(if0.slot),    9'd0);
    chk("rst_sync", 9'(if0.sync),    9'd1);
    chk("rst_dbg",  9'(if0.dbg_out), 9'd0);
    adv();

    // counting: 15 periods, each slot reads 0..4 on successive visits
    for (int p = 0; p < 15; p++)
      period("count", 1, 0, 0, 0, p % S, p / S, p / S, 0, 0);

    // wrap vs saturate on slot 1 (all slots now hold 5)
    period("sat_s0a", 0, 0, 0, 0, 0, 5, 5, 0, 0);
    period("sat_load", 3, 0, 1, 14, 1, 5, 5, 1, 1);
    period("sat_s2a", 0, 0, 0, 0, 2, 5, 5, -1, -1);
    period("sat_s0b", 0, 0, 0, 0, 0, 5, 5, -1, -1);
    period("sat_again", 3, 0, 0, 0, 1, 1, 15, 0, 1);
    period("sat_s2b", 0, 0, 0, 0, 2, 5, 5, -1, -1);
    period("sat_s0c", 0, 0, 0, 0, 0, 5, 5, -1, -1);
    period("sat_hold", 0, 0, 0, 0, 1, 4, 15, -1, -1);

    // priority on slot 2: clr beats load, then load alone
    period("pri_clr", 0, 1, 1, 9, 2, 5, 5, 0, 0);
    period("pri_s0a", 0, 0, 0, 0, 0, 5, 5, -1, -1);
    period("pri_s1a", 0, 0, 0, 0, 1, 4, 15, -1, -1);
    period("pri_load", 0, 0, 1, 9, 2, 0, 0, -1, -1);
    period("pri_s0b", 0, 0, 0, 0, 0, 5, 5, -1, -1);
    period("pri_s1b", 0, 0, 0, 0, 1, 4, 15, -1, -1);
    period("pri_clrc", 3, 1, 1, 15, 2, 9, 9, 1, 1);

    // bring slots to 5, 7, 2 and confirm
    period("set_s0", 0, 0, 1, 5, 0, 5, 5, -1, -1);
    period("set_s1", 0, 0, 1, 7, 1, 4, 15, -1, -1);
    period("set_s2", 0, 0, 1, 2, 2, 0, 0, -1, -1);
    period("chk_s0", 0, 0, 0, 0, 0, 5, 5, -1, -1);
    period("chk_s1", 0, 0, 0, 0, 1, 7, 7, -1, -1);
    period("chk_s2", 0, 0, 0, 0, 2, 2, 2, -1, -1);

    // reset mid-rotation with c2 high
    set_in(1, 0, 1, 0, 0, 0, 0, 0, 0);
    adv();
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 1);
    adv();
    set_in(0, 0, 1, 0, 1, 15, 0, 0, 0);
    chk("mrst_val",  9'(if0.val),     9'd0);
    chk("mrst_slot", 9'(if0.slot),    9'd0);
    chk("mrst_sync", 9'(if0.sync),    9'd1);
    chk("mrst_dbg",  9'(if0.dbg_out), 9'd0);
    chk("mrst_cout", 9'(if0.c_out),   9'd1);
    adv();
    for (int p = 0; p < S; p++)
      period("mrst_rot", 0, 0, 0, 0, p, 0, 0, -1, -1);

    // debug chain: head 1010 on slot 0, merge then shift out MSB first
    period("dbg_set", 0, 0, 1, 10, 0, 0, 0, -1, -1);
    period("dbg_s1", 0, 0, 0, 0, 1, 0, 0, -1, -1);
    period("dbg_s2", 0, 0, 0, 0, 2, 0, 0, -1, -1);
    set_in(1, 0, 0, 0, 0, 0, 1, 0, 0);
    adv();
    for (int i = 0; i < 5; i++) begin
      set_in(i < 4, 0, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("dbg_bit%0d", i), 9'(if0.dbg_out), 9'(dbg_exp[i]));
      adv();
    end

    // overlapped / random phases against the model
    for (int n = 0; n < 50; n++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15),
             $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 0);
      adv();
    end
    set_in(1, 1, 2, 0, 0, 0, 0, 1, 0);
    adv();

    // drain
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    sb_on = 0;
    repeat (2) adv();
    chk("drain0", 9'(exp0_q.size()), 9'd0);
    chk("drain1", 9'(exp1_q.size()), 9'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
